// File: rtl/reg16_bit_bypass.sv
// 16-bit storage register with write-through output: a selected write is visible on DOut in the same cycle.
// Optional synchronous clear enabled by defining REG16_BIT_BYPASS_CLR_EN (adds input port clr).
module reg16_bit_bypass #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef REG16_BIT_BYPASS_CLR_EN
    input  logic             clr,
`endif
    input  logic [WIDTH-1:0] DIn,
    input  logic             cs,
    input  logic             w,
    output logic [WIDTH-1:0] DOut
);

    logic             we_s;
    logic             clr_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dout_s;

    assign we_s = cs & w;

`ifdef REG16_BIT_BYPASS_CLR_EN
    assign clr_s = clr;
`else
    assign clr_s = 1'b0;
`endif

    // storage register: clear wins over write, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else if (clr_s) begin
            q_r <= {WIDTH{1'b0}};
        end else if (we_s) begin
            q_r <= DIn;
        end else begin
            q_r <= q_r;
        end
    end

    // output select: reset forces zero even mid-write, clear bypasses like a write of zero
    always_comb begin
        dout_s = {WIDTH{1'b0}};
        if (!rst_n) begin
            dout_s = {WIDTH{1'b0}};
        end else if (clr_s) begin
            dout_s = {WIDTH{1'b0}};
        end else if (we_s) begin
            dout_s = DIn;
        end else begin
            dout_s = q_r;
        end
    end

    assign DOut = dout_s;

endmodule

// File: tb/tb_reg16_bit_bypass.sv
// Self-checking bench for reg16_bit_bypass: directed scenarios plus randomized traffic against a behavioural model.
// Exercises the clr port only when REG16_BIT_BYPASS_CLR_EN is defined.
module tb_reg16_bit_bypass;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [WIDTH-1:0] DIn;
    logic             cs;
    logic             w;
    logic [WIDTH-1:0] DOut;

    int checks;
    int failures;
    bit cmp_en;

    // model state: the value the register must be holding
    logic [WIDTH-1:0] mq;

    reg16_bit_bypass #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef REG16_BIT_BYPASS_CLR_EN
        .clr   (clr),
`endif
        .DIn   (DIn),
        .cs    (cs),
        .w     (w),
        .DOut  (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_dout();
        bit clr_on;
`ifdef REG16_BIT_BYPASS_CLR_EN
        clr_on = (clr === 1'b1);
`else
        clr_on = 1'b0;
`endif
        if (rst_n !== 1'b1) return {WIDTH{1'b0}};
        if (clr_on) return {WIDTH{1'b0}};
        if (cs && w) return DIn;
        return mq;
    endfunction

    // Advance one rising edge, apply storage rules to the model, settle 1 time unit past the edge
    task automatic tick();
        bit clr_on;
        @(posedge clk);
`ifdef REG16_BIT_BYPASS_CLR_EN
        clr_on = (clr === 1'b1);
`else
        clr_on = 1'b0;
`endif
        if (rst_n === 1'b1) begin
            if (clr_on) mq = {WIDTH{1'b0}};
            else if (cs && w) mq = DIn;
        end
        #1;
    endtask

    task automatic assert_rst();
        rst_n = 1'b0;
        mq    = {WIDTH{1'b0}};
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] exp);
        checks++;
        if (DOut !== exp) begin
            failures++;
            $display("FAIL %s: DOut=%h expected=%h at %0t", name, DOut, exp, $time);
        end
    endtask

    // Continuous compare against the model in the middle of every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [WIDTH-1:0] e;
            e = exp_dout();
            checks++;
            if (DOut !== e) begin
                failures++;
                $display("FAIL model_cmp: DOut=%h expected=%h cs=%b w=%b rst_n=%b DIn=%h at %0t",
                         DOut, e, cs, w, rst_n, DIn, $time);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] seq [3];
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        clr      = 1'b0;
        cs       = 1'b0;
        w        = 1'b0;
        DIn      = {WIDTH{1'b0}};
        mq       = {WIDTH{1'b0}};
        rst_n    = 1'b0;
        #2;
        chk("reset_initial", 16'h0000);
        cmp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1 chk("after_release", 16'h0000);

        // async reset with 1234 stored
        cs = 1'b1; w = 1'b1; DIn = 16'h1234;
        tick();
        cs = 1'b0; w = 1'b0;
        #1 chk("stored_1234", 16'h1234);
        assert_rst();
        #1 chk("async_reset_immediate", 16'h0000);
        tick();
        rst_n = 1'b1;
        #1 chk("release_cs0", 16'h0000);
        tick();
        chk("release_cs0_next", 16'h0000);

        // write with bypass, then hold while DIn changes
        cs = 1'b1; w = 1'b1; DIn = 16'hA5A5;
        #1 chk("bypass_a5a5", 16'hA5A5);
        tick();
        w = 1'b0; DIn = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_a5a5", 16'hA5A5);
            tick();
        end

        // deselected write and cs=1,w=0 are both ignored
        cs = 1'b1; w = 1'b1; DIn = 16'h00FF;
        tick();
        cs = 1'b0; w = 1'b1; DIn = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("cs0_ignored", 16'h00FF);
            tick();
        end
        cs = 1'b1; w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("w0_ignored", 16'h00FF);
            tick();
        end

        // back-to-back writes
        seq[0] = 16'h0001; seq[1] = 16'h0002; seq[2] = 16'hFFFF;
        cs = 1'b1; w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DIn = seq[i];
            #1 chk("b2b_bypass", seq[i]);
            tick();
        end
        w = 1'b0; DIn = 16'h0000;
        #1 chk("b2b_final", 16'hFFFF);
        tick();

        // reset pulse in the middle of a write
        cs = 1'b1; w = 1'b1; DIn = 16'h7777;
        #1 chk("pre_reset_bypass", 16'h7777);
        assert_rst();
        #1 chk("reset_mid_write", 16'h0000);
        w = 1'b0;
        #1 rst_n = 1'b1;
        #1 chk("post_reset_release", 16'h0000);
        tick();
        chk("post_reset_edge", 16'h0000);

`ifdef REG16_BIT_BYPASS_CLR_EN
        // clear has priority over a simultaneous write
        cs = 1'b1; w = 1'b1; DIn = 16'hBEEF;
        tick();
        w = 1'b0;
        #1 chk("stored_beef", 16'hBEEF);
        clr = 1'b1; w = 1'b1; DIn = 16'h1234;
        #1 chk("clr_bypass_zero", 16'h0000);
        tick();
        clr = 1'b0; w = 1'b0;
        #1 chk("clr_stored_zero", 16'h0000);
        tick();
`endif

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            if (rst_n == 1'b0) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                assert_rst();
            end
            cs  = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 2) == 0);
            DIn = WIDTH'($urandom);
`ifdef REG16_BIT_BYPASS_CLR_EN
            clr = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
        rst_n = 1'b1;
        cs = 1'b0; w = 1'b0; clr = 1'b0;
        tick();
        tick();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg16_bit_bypass.md
Name: reg16_bit_bypass

Overview:
- 16-bit storage register with write-through (bypass) output.
- When the register is selected and write-enabled, DOut shows DIn in the same cycle, and DIn is captured on the next rising clock edge.
- Otherwise DOut shows the stored value.
- Used as the state register inside the program counter. Read gating (cs & r) is done outside this block.

Parameters:
- WIDTH, 16, data width of DIn/DOut and the stored value. All requirements below scale with WIDTH.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- DIn  input  WIDTH  write data.
- cs  input  1  chip select; active high.
- w  input  1  write enable; active high; effective only when cs=1.
- DOut  output  WIDTH  bypassed or stored data.
- clr  input  1  synchronous clear; present only with the optional feature (see Optional Feature).

Behaviour:
- Internal signal: we = cs & w.
- Storage q (WIDTH bits):
  - rst_n low: q = 0 immediately, without waiting for a clock edge.
  - Rising edge of clk with rst_n high and we=1: q <= DIn.
  - Rising edge with we=0: q holds.
- Output (purely combinational, no registered latency):
  - rst_n low: DOut = 0, regardless of we or DIn.
  - rst_n high and we=1: DOut = DIn (bypass, zero-cycle latency).
  - rst_n high and we=0: DOut = q.
- Write latency: a value written at edge N is visible from q at DOut starting at edge N, once we drops. During the write cycle it is already visible through the bypass.
- cs=0: w is ignored, q holds, DOut = q. There is no high-Z or X output; DOut is always driven.
- cs=1, w=0: hold; DOut = q.
- DIn changing while we=1: DOut follows DIn combinationally. Only the value present at the rising edge is stored.
- Reset asserted mid-write: reset wins; q = 0 and DOut = 0. On deassertion, the next rising edge with we=1 stores DIn.
- Reset deassertion coincident with a clock edge: that edge does not write. The first write occurs on the following edge.
- No overflow or wrap semantics; the block is pure storage.
- All state bits must reset; there must be no X on DOut after reset.

Optional Feature:
- Macro: REG16_BIT_BYPASS_CLR_EN.
- Defined:
  - Adds input port clr (1 bit, active high, synchronous).
  - On a rising edge with rst_n high and clr=1, q <= 0. clr has priority over we.
  - While clr=1 (rst_n high), DOut = 0. clr bypasses just like a write of zero.
- Not defined:
  - Port clr is absent.
  - Behaviour is exactly as specified above.

Test Plan:
- Reset: assert rst_n=0 asynchronously with q previously 16'h1234 -> DOut = 16'h0000 immediately, before any clock edge. Release rst_n with cs=0 -> DOut stays 16'h0000.
- Write and bypass: cs=1, w=1, DIn=16'hA5A5 -> DOut = 16'hA5A5 before the edge. After the edge, set w=0 -> DOut = 16'hA5A5 held for 5 cycles while DIn changes to 16'hFFFF.
- Deselected write ignored: q=16'h00FF; cs=0, w=1, DIn=16'h1111 over 3 edges -> DOut = 16'h00FF throughout. Repeat with cs=1, w=0 -> DOut = 16'h00FF.
- Back-to-back writes: we=1 on consecutive edges with DIn = 16'h0001, 16'h0002, 16'hFFFF -> DOut tracks each value in-cycle. After we drops, DOut = 16'hFFFF.
- Reset mid-write: we=1, DIn=16'h7777, rst_n pulsed low between edges -> DOut = 0 while low. After release with we=0 -> DOut = 16'h0000, not 16'h7777.
- With REG16_BIT_BYPASS_CLR_EN: q=16'hBEEF; clr=1 and we=1 with DIn=16'h1234 -> DOut = 0 during the cycle. After the edge with clr=0 and we=0 -> DOut = 16'h0000.
